// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and constants for the serial two-bit tandem comparator.
package serial_compare_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Cascade encoding {eq,gt}
  localparam logic [1:0] CASC_EQ = 2'b10;
  localparam logic [1:0] CASC_GT = 2'b01;
  localparam logic [1:0] CASC_LT = 2'b00;

  // Width of the digit counter for n digit cycles: clog2(n), never below 1
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_compare_ctrl_tcs_cell.sv
// One two-bit tandem comparator cell: refines the incoming cascade with one digit pair.
module tcs_cell
  import serial_compare_ctrl_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       eq_in,
  input  logic       gt_in,
  output logic       eq_out,
  output logic       gt_out
);

  // Still equal so far: this digit decides; otherwise hold the earlier decision
  always_comb begin
    eq_out = 1'b0;
    gt_out = 1'b0;
    if (eq_in) begin
      eq_out = (a == b);
      gt_out = (a > b);
    end else begin
      eq_out = 1'b0;
      gt_out = gt_in;
    end
  end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial front end: feeds two WIDTH-bit operands MSB-first, one digit pair per
// clock, through a single comparator cell whose cascade is registered back.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = cnt_width(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       casc_q, casc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rv_q, rv_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             cell_eq_s;
  logic             cell_gt_s;

  tcs_cell u_cell (
    .a      (a_sh_q[WIDTH-1 -: 2]),
    .b      (b_sh_q[WIDTH-1 -: 2]),
    .eq_in  (casc_q[1]),
    .gt_in  (casc_q[0]),
    .eq_out (cell_eq_s),
    .gt_out (cell_gt_s)
  );

  // Next-state and next-output logic; start is honoured in IDLE and DONE alike
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    casc_d  = casc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rv_d    = rv_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          casc_d  = CASC_EQ;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
          rv_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q << 2;
        b_sh_d = b_sh_q << 2;
        casc_d = {cell_eq_s, cell_gt_s};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rv_d    = 1'b1;
          eq_d    = cell_eq_s;
          gt_d    = cell_gt_s;
          lt_d    = ~cell_eq_s & ~cell_gt_s;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      casc_q  <= 2'b00;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      casc_q  <= casc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign eq           = eq_q;
  assign gt           = gt_q;
  assign lt           = lt_q;

endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequential front end for the two-bit tandem comparator stage. Accepts two WIDTH-bit unsigned operands on a start strobe, then feeds them MSB-first, one 2-bit digit pair per clock, through a single comparator cell. The cell's cascade outputs are registered back into its own cascade inputs. After WIDTH/2 digit cycles the block reports equal / greater / less with a one-cycle done pulse. It replaces a chain of WIDTH/2 cascaded comparator cells with one cell plus a small controller.

## Interface
- WIDTH, 8: operand width in bits; must be even and ≥ 2; N = WIDTH/2 digit cycles per compare.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when the block is not busy.
- a_in  in  WIDTH  operand A, unsigned; captured on the accepted start edge.
- b_in  in  WIDTH  operand B, unsigned; captured on the accepted start edge.
- busy  out  1  high while digits are being consumed (RUN).
- done  out  1  one-cycle pulse; the result is valid from this cycle onward.
- result_valid  out  1  high from done until the next accepted start.
- eq  out  1  A == B.
- gt  out  1  A > B.
- lt  out  1  A < B.

## Operation
- Cascade encoding {eq,gt}: 10 means equal so far, 01 means greater, 00 means less. The seed for the first digit is 10.
- Cell rule per digit (a2,b2):
  - If incoming eq=1: eq'=(a2==b2) and gt'=(a2>b2).
  - Otherwise: eq'=0 and gt'=gt, so a decision made at a higher digit is held.
- States:
  - IDLE: start=1 → capture a_in/b_in into shift registers, cascade regs ← 10, digit counter ← N-1, result_valid ← 0, go to RUN.
  - RUN: each edge consumes the top digit pair, shifts both operands left by 2, and updates the cascade regs. When counter==0, latch eq/gt/lt from the final cell output and go to DONE. Otherwise decrement the counter.
  - DONE: done=1 and result_valid ← 1. start=1 behaves as in IDLE (back-to-back compare). Otherwise go to IDLE.
- lt = ~eq & ~gt, computed from the final cascade value. Exactly one of eq/gt/lt is high whenever result_valid=1.
- eq/gt/lt update only on the completing edge. Between starts they hold the last result; during RUN they keep the stale value with result_valid=0.
- start during RUN is ignored. Operand inputs are don't-care outside the accept edge.
- There is no early termination: latency is fixed regardless of data.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy, done, result_valid, eq, gt, lt all 0; shift, cascade and counter regs cleared. Reset has priority over start.
- Reset asserted mid-RUN or in DONE aborts the compare. No done pulse is produced for the aborted operation.
- Accept edge k → busy=1 from k. Digit i (i=0 is the MSB pair) is consumed at edge k+1+i. The final digit is consumed at edge k+N.
- done=1 and busy=0 in the cycle following edge k+N. Start-to-done latency is N+1 edges, i.e. 5 for WIDTH=8.
- Back-to-back: start asserted in the DONE cycle is accepted on that edge. Throughput is one compare per N+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the cascade encoding constants (CASC_EQ=2'b10, CASC_GT=2'b01, CASC_LT=2'b00);
  - a counter width function, clog2(N), minimum 1.
- One combinational sub-module, tcs_cell: 2-bit a, 2-bit b, eq_in, gt_in → eq_out, gt_out. It is instantiated once, with the controller registers around it.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start at edge k → done at k+5, eq=1, gt=0, lt=0, result_valid=1.
- a=0x80, b=0x7F → gt=1 at done. Decided at the MSB digit (2 vs 1); the three lower digits must not change it.
- a=0x3C, b=0x3D → lt=1. Decided only at the last digit (0 vs 1).
- start pulsed again at k+2 during RUN with different operands → ignored; the original compare finishes at k+5 with its own result.
- start held in the DONE cycle with a=0x01, b=0x00 → accepted; busy=1 next cycle, result_valid=0; second done exactly 5 edges later with gt=1.
- rst_n=0 at k+3 of a compare → all outputs 0 the next cycle, no done pulse. The next start completes normally.
